// File: rtl/demux_vc_entrada_if.sv
// demux_vc_entrada_if: ingress handshake plus VC0/VC1 FIFO push bundle for demux_vc_entrada.
interface demux_vc_entrada_if #(parameter int BW = 6, parameter int CNT_W = 8);
    logic [BW-1:0]    data_in;
    logic             valid_in;
    logic             ready_in;
    logic             almost_full_fifo_VC0;
    logic             almost_full_fifo_VC1;
    logic             VC0_push;
    logic             VC1_push;
    logic [BW-1:0]    data_VC0;
    logic [BW-1:0]    data_VC1;
    logic             idle;
    logic [CNT_W-1:0] cnt_VC0;
    logic [CNT_W-1:0] cnt_VC1;
    modport master (
        output data_in, valid_in, almost_full_fifo_VC0, almost_full_fifo_VC1,
        input  ready_in, VC0_push, VC1_push, data_VC0, data_VC1, idle, cnt_VC0, cnt_VC1
    );
    modport slave (
        input  data_in, valid_in, almost_full_fifo_VC0, almost_full_fifo_VC1,
        output ready_in, VC0_push, VC1_push, data_VC0, data_VC1, idle, cnt_VC0, cnt_VC1
    );
endinterface

// File: rtl/demux_vc_entrada.sv
// demux_vc_entrada: 2-entry buffered, in-order VC0/VC1 demux on data bit VC_BIT.
// Define DEMUX_VC_CONTADORES_EN to build the per-VC push counters.
module demux_vc_entrada #(
    parameter int BW     = 6,
    parameter int VC_BIT = 4,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               reset_L,
    demux_vc_entrada_if.slave bus
);
    localparam logic [1:0] VACIO = 2'd0, UNO = 2'd1, LLENO = 2'd2;
    logic [1:0]    state, state_nxt;
    logic [BW-1:0] b0, b1, b0_nxt, b1_nxt, head;
    logic          accept, issue, pop, store, to_vc1;
    assign bus.ready_in = state != LLENO && reset_L;
    assign bus.idle = state == VACIO && !bus.VC0_push && !bus.VC1_push;
    // An empty buffer lets the incoming word act as head (bypass).
    always_comb begin
        accept    = bus.valid_in && bus.ready_in;
        head      = state == VACIO ? bus.data_in : b0;
        to_vc1    = head[VC_BIT];
        issue     = (state != VACIO || accept) && (to_vc1 ? !bus.almost_full_fifo_VC1 : !bus.almost_full_fifo_VC0);
        pop       = issue && state != VACIO;
        store     = accept && !(state == VACIO && issue);
        state_nxt = store && !pop ? state + 2'd1 : !store && pop ? state - 2'd1 : state;
        b0_nxt    = pop ? (state == LLENO ? b1 : bus.data_in) : (state == VACIO ? bus.data_in : b0);
        b1_nxt    = state == UNO && !pop ? bus.data_in : b1;
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= VACIO;
            b0           <= '0;
            b1           <= '0;
            bus.VC0_push <= 1'b0;
            bus.VC1_push <= 1'b0;
            bus.data_VC0 <= '0;
            bus.data_VC1 <= '0;
        end else begin
            state        <= state_nxt;
            b0           <= b0_nxt;
            b1           <= b1_nxt;
            bus.VC0_push <= issue && !to_vc1;
            bus.VC1_push <= issue && to_vc1;
            if (issue && !to_vc1) bus.data_VC0 <= head;
            if (issue && to_vc1) bus.data_VC1 <= head;
        end
    end
`ifdef DEMUX_VC_CONTADORES_EN
    logic [CNT_W-1:0] cnt0, cnt1;
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + CNT_W'(bus.VC0_push);
            cnt1 <= cnt1 + CNT_W'(bus.VC1_push);
        end
    end
    assign bus.cnt_VC0 = cnt0;
    assign bus.cnt_VC1 = cnt1;
`else
    assign bus.cnt_VC0 = '0;
    assign bus.cnt_VC1 = '0;
`endif
endmodule

// File: tb/tb_demux_vc_entrada.sv
// tb_demux_vc_entrada: directed stimulus with an in-order push scoreboard for demux_vc_entrada.
module tb_demux_vc_entrada;
    logic clk = 1'b0;
    logic reset_L;
    int   n_chk = 0;
    int   n_err = 0;
    logic [5:0] sb[$];
    bit   acc;

    demux_vc_entrada_if #(.BW(6), .CNT_W(8)) bus ();
    demux_vc_entrada #(.BW(6), .VC_BIT(4), .CNT_W(8)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log an accepted word, then compare any push against the oldest expected word.
    task automatic tick(output bit a);
        logic [5:0] w;
        a = bus.valid_in && bus.ready_in;
        if (a) sb.push_back(bus.data_in);
        @(posedge clk);
        #1;
        if (bus.VC0_push || bus.VC1_push) begin
            chk("push_onehot", 32'(bus.VC0_push & bus.VC1_push), 0);
            if (sb.size() == 0) chk("spurious_push", 32'({bus.VC0_push, bus.VC1_push}), 0);
            else begin
                w = sb.pop_front();
                chk("push_vc", 32'(bus.VC1_push), 32'(w[4]));
                chk("push_data", 32'(w[4] ? bus.data_VC1 : bus.data_VC0), 32'(w));
            end
        end
    endtask

    initial begin
        reset_L = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in = 6'h15;
        bus.almost_full_fifo_VC0 = 1'b0;
        bus.almost_full_fifo_VC1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready_in), 0);
        chk("rst_push", 32'({bus.VC0_push, bus.VC1_push}), 0);
        chk("rst_data", 32'({bus.data_VC0, bus.data_VC1}), 0);
        chk("rst_idle", 32'(bus.idle), 1);
        chk("rst_cnt", 32'({bus.cnt_VC0, bus.cnt_VC1}), 0);
        bus.valid_in = 1'b0;
        reset_L = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.ready_in), 1);
        chk("rel_idle", 32'(bus.idle), 1);

        // Bypass: each word pushed the cycle after acceptance.
        bus.valid_in = 1'b1;
        bus.data_in = 6'h05;
        tick(acc);
        chk("byp0_push", 32'({bus.VC0_push, bus.data_VC0}), 32'({1'b1, 6'h05}));
        chk("byp0_ready", 32'(bus.ready_in), 1);
        bus.data_in = 6'h15;
        tick(acc);
        chk("byp0_acc", 32'(acc), 1);
        chk("byp1_push", 32'({bus.VC1_push, bus.data_VC1}), 32'({1'b1, 6'h15}));
        bus.valid_in = 1'b0;
        tick(acc);
        chk("byp_idle", 32'(bus.idle), 1);
        chk("byp_hold", 32'(bus.data_VC0), 32'h05);

        // Head-of-line blocking behind a full VC0.
        bus.almost_full_fifo_VC0 = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in = 6'h03;
        tick(acc);
        chk("hol_acc03", 32'(acc), 1);
        chk("hol_nopush1", 32'({bus.VC0_push, bus.VC1_push}), 0);
        bus.data_in = 6'h13;
        tick(acc);
        chk("hol_acc13", 32'(acc), 1);
        chk("hol_nopush2", 32'({bus.VC0_push, bus.VC1_push}), 0);
        chk("hol_ready_low", 32'(bus.ready_in), 0);
        bus.data_in = 6'h07;
        repeat (2) begin
            tick(acc);
            chk("hol_held07", 32'(acc), 0);
            chk("hol_nopush3", 32'({bus.VC0_push, bus.VC1_push}), 0);
        end
        bus.almost_full_fifo_VC0 = 1'b0;
        tick(acc);
        chk("hol_rel_03", 32'({bus.VC0_push, bus.data_VC0}), 32'({1'b1, 6'h03}));
        chk("hol_rel_ready", 32'(bus.ready_in), 1);
        tick(acc);
        chk("hol_acc07", 32'(acc), 1);
        chk("hol_rel_13", 32'({bus.VC1_push, bus.data_VC1}), 32'({1'b1, 6'h13}));
        bus.valid_in = 1'b0;
        tick(acc);
        chk("hol_rel_07", 32'({bus.VC0_push, bus.data_VC0}), 32'({1'b1, 6'h07}));
        tick(acc);
        chk("hol_idle", 32'(bus.idle), 1);

        // Park one word to reach UNO, then stream 10 words through with no stall.
        bus.almost_full_fifo_VC0 = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in = 6'h01;
        tick(acc);
        bus.almost_full_fifo_VC0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.data_in = 6'((i % 2) << 4 | (i + 2));
            tick(acc);
            chk("uno_acc", 32'(acc), 1);
            chk("uno_ready", 32'(bus.ready_in), 1);
            chk("uno_push", 32'(bus.VC0_push | bus.VC1_push), 1);
            chk("uno_idle", 32'(bus.idle), 0);
        end
        bus.valid_in = 1'b0;
        repeat (2) tick(acc);
        chk("uno_drained", 32'(sb.size()), 0);
        chk("uno_idle_end", 32'(bus.idle), 1);

        // Reset while LLENO: buffered words must be dropped.
        bus.almost_full_fifo_VC0 = 1'b1;
        bus.almost_full_fifo_VC1 = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in = 6'h02;
        tick(acc);
        bus.data_in = 6'h12;
        tick(acc);
        chk("mid_lleno", 32'(bus.ready_in), 0);
        bus.valid_in = 1'b0;
        reset_L = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ready_in), 0);
        #2;
        reset_L = 1'b1;
        sb.delete();
        bus.almost_full_fifo_VC0 = 1'b0;
        bus.almost_full_fifo_VC1 = 1'b0;
        repeat (3) begin
            tick(acc);
            chk("mid_nopush", 32'({bus.VC0_push, bus.VC1_push}), 0);
        end
        chk("mid_idle", 32'(bus.idle), 1);
        chk("mid_ready", 32'(bus.ready_in), 1);

        // 257 VC1 pushes wrap an 8-bit counter to 1.
        bus.valid_in = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.data_in = 6'(6'h10 | (i & 15));
            tick(acc);
        end
        bus.valid_in = 1'b0;
        tick(acc);
`ifdef DEMUX_VC_CONTADORES_EN
        chk("cnt_vc1", 32'(bus.cnt_VC1), 1);
`else
        chk("cnt_vc1", 32'(bus.cnt_VC1), 0);
`endif
        chk("cnt_vc0", 32'(bus.cnt_VC0), 0);
        chk("end_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
